// File: rtl/mux151_scan_ctrl.sv
// Scan controller for an IC74HC151 8:1 mux: walks every select value, samples Y/YF and
// assembles a readback word. Optional macro MUX151_SCAN_AUTO_EN enables back-to-back scans.
module mux151_scan_ctrl #(
  parameter int DATA_SelectPart  = 3,
  parameter int DATA_Single_Part = 8,
  parameter int SETTLE_CYCLES    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        Start,
  output logic                        Busy,
  output logic                        Done,
  output logic                        EN_Part,
  output logic [DATA_SelectPart-1:0]  SelectPart,
  input  logic                        Y,
  input  logic                        YF,
  output logic [DATA_Single_Part-1:0] Word,
  output logic                        Err
);

  localparam int N = 2 ** DATA_SelectPart;
  localparam logic [7:0] SETTLE_RELOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [DATA_SelectPart-1:0] SEL_LAST = DATA_SelectPart'(N - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e                        state_q;
  logic [7:0]                    cnt_q;
  logic [DATA_SelectPart-1:0]    sel_q;
  logic [DATA_Single_Part-1:0]   shadow_q;
  logic [DATA_Single_Part-1:0]   word_q;
  logic                          flag_q;
  logic                          err_q;
  logic                          busy_q;
  logic                          done_q;
  logic                          en_n_q;
  logic [DATA_SelectPart-1:0]    sel_d;
  logic                          scan_go_d;

  // A new scan is launched from IDLE, or straight out of DONE when auto-repeat is built in.
  always_comb begin
    sel_d     = sel_q + 1'b1;
    scan_go_d = (state_q == IDLE) && Start;
`ifdef MUX151_SCAN_AUTO_EN
    if ((state_q == DONE) && Start) scan_go_d = 1'b1;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register here
  // sees the pre-edge value of every other register regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_q    <= '0;
      shadow_q <= '0;
      word_q   <= '0;
      flag_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      en_n_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: ;
        SETTLE: begin
          if (cnt_q == 8'd0) state_q <= SAMPLE;
          else               cnt_q   <= cnt_q - 8'd1;
        end
        SAMPLE: begin
          shadow_q[sel_q] <= Y;
          if (YF == Y) flag_q <= 1'b1;
          if (sel_q == SEL_LAST) begin
            state_q <= DONE;
          end else begin
            sel_q   <= sel_d;
            cnt_q   <= SETTLE_RELOAD;
            state_q <= SETTLE;
          end
        end
        DONE: begin
          word_q  <= shadow_q;
          err_q   <= flag_q;
          done_q  <= 1'b1;
          en_n_q  <= 1'b1;
          busy_q  <= 1'b0;
          sel_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Launch overrides the DONE wind-down so Busy/EN stay asserted between auto scans.
      if (scan_go_d) begin
        state_q  <= SETTLE;
        sel_q    <= '0;
        en_n_q   <= 1'b0;
        busy_q   <= 1'b1;
        shadow_q <= '0;
        flag_q   <= 1'b0;
        cnt_q    <= SETTLE_RELOAD;
      end
    end
  end

  assign Busy       = busy_q;
  assign Done       = done_q;
  assign EN_Part    = en_n_q;
  assign SelectPart = sel_q;
  assign Word       = word_q;
  assign Err        = err_q;

endmodule

// File: tb/tb_mux151_scan_ctrl.sv
// Directed bench for mux151_scan_ctrl using behavioural 74HC151 models; expected
// edges/words are hand-computed and adapt to MUX151_SCAN_AUTO_EN.
module tb_mux151_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_a, busy_a, done_a, en_a, y_a, yf_a, err_a, force_a;
  logic [2:0] sel_a;
  logic [7:0] word_a, data_a;
  logic       start_b, busy_b, done_b, en_b, y_b, yf_b, err_b;
  logic [2:0] sel_b;
  logic [7:0] word_b, data_b;

  // 74HC151: disabled -> Y=0, W=1; force_a shorts YF to Y while select is 5.
  assign y_a  = en_a ? 1'b0 : data_a[sel_a];
  assign yf_a = (force_a && sel_a == 3'd5) ? y_a : ~y_a;
  assign y_b  = en_b ? 1'b0 : data_b[sel_b];
  assign yf_b = ~y_b;

  mux151_scan_ctrl #(.SETTLE_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .Start(start_a), .Busy(busy_a), .Done(done_a),
    .EN_Part(en_a), .SelectPart(sel_a), .Y(y_a), .YF(yf_a), .Word(word_a), .Err(err_a)
  );

  mux151_scan_ctrl #(.SETTLE_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .Start(start_b), .Busy(busy_b), .Done(done_b),
    .EN_Part(en_b), .SelectPart(sel_b), .Y(y_b), .YF(yf_b), .Word(word_b), .Err(err_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input bit which);
    @(negedge clk);
    if (which) start_b = 1'b1;
    else       start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Pulses Start (edge 0), then observes 45 edges: Done edge/count, Busy length, select walk.
  task automatic run_scan(input bit which, input string tag, input int settle,
                          input int exp_edge, input logic [7:0] exp_word,
                          input bit exp_err, input int restart_at);
    int first = -1;
    int ndone = 0;
    int nbusy = 0;
    int sel_bad = 0;
    int exp_sel;
    pulse_start(which);
    @(negedge clk);
    if (which ? busy_b : busy_a) nbusy++;
    if ((which ? sel_b : sel_a) != 3'd0) sel_bad++;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
      @(negedge clk);
      if (which ? done_b : done_a) begin
        ndone++;
        if (first < 0) first = k;
      end
      if (which ? busy_b : busy_a) nbusy++;
      if (k < exp_edge) begin
        exp_sel = k / (settle + 1);
        if (exp_sel > 7) exp_sel = 7;
        if ((which ? sel_b : sel_a) != 3'(exp_sel)) sel_bad++;
      end
      if (k == restart_at - 1) begin
        if (which) start_b = 1'b1;
        else       start_a = 1'b1;
      end
    end
    check({tag, "_done_edge"}, first, exp_edge);
    check({tag, "_done_count"}, ndone, 1);
    check({tag, "_busy_cycles"}, nbusy, exp_edge);
    check({tag, "_sel_walk_errs"}, sel_bad, 0);
    check({tag, "_word"}, which ? word_b : word_a, exp_word);
    check({tag, "_err"}, which ? err_b : err_a, exp_err);
    check({tag, "_en_idle"}, which ? en_b : en_a, 1'b1);
    check({tag, "_sel_idle"}, which ? sel_b : sel_a, 3'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   found;
    int   ndone;
    int   edges [3];
    logic [7:0] words [3];
`ifdef MUX151_SCAN_AUTO_EN
    int exp_edges [3] = '{17, 34, 51};
`else
    int exp_edges [3] = '{17, 35, 53};
`endif

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; force_a = 1'b0;
    data_a = 8'hBD; data_b = 8'hBD;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_en", en_a, 1'b1);
    check("rst_sel", sel_a, 3'd0);
    check("rst_word", word_a, 8'h00);
    check("rst_err", err_a, 1'b0);
    rst = 1'b0;

    run_scan(1'b0, "basic", 1, 17, 8'hBD, 1'b0, 0);
    run_scan(1'b1, "settle3", 3, 33, 8'hBD, 1'b0, 0);

    force_a = 1'b1;
    run_scan(1'b0, "yf_err", 1, 17, 8'hBD, 1'b1, 0);
    force_a = 1'b0;
    run_scan(1'b0, "clean", 1, 17, 8'hBD, 1'b0, 0);

    // Reset while the scan is on select 3.
    pulse_start(1'b0);
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      @(negedge clk);
      if (sel_a == 3'd3) found = 1;
    end
    check("midrst_reach_sel3", found, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy_a, 1'b0);
    check("midrst_en", en_a, 1'b1);
    check("midrst_sel", sel_a, 3'd0);
    check("midrst_word", word_a, 8'h00);
    check("midrst_err", err_a, 1'b0);
    ndone = 0;
    if (done_a) ndone++;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done_a) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    run_scan(1'b0, "after_rst", 1, 17, 8'hBD, 1'b0, 0);

    run_scan(1'b0, "restart_ignored", 1, 17, 8'hBD, 1'b0, 5);

    // Start held high across three scans; data changes after the first Done.
    @(negedge clk);
    start_a = 1'b1;
    ndone = 0;
    for (int k = 0; k <= 70 && ndone < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_a) begin
        edges[ndone] = k;
        words[ndone] = word_a;
        ndone++;
        if (ndone == 1) data_a = 8'h5A;
        if (ndone == 3) start_a = 1'b0;
      end
    end
    start_a = 1'b0;
    check("hold_done_count", ndone, 3);
    for (int i = 0; i < 3; i++) begin
      if (i < ndone) begin
        check($sformatf("hold_edge%0d", i), edges[i], exp_edges[i]);
        check($sformatf("hold_word%0d", i), words[i], (i == 0) ? 8'hBD : 8'h5A);
      end
    end
    repeat (25) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
